// File: rtl/rmii_rx_fcs_check.sv
// RMII 100 Mb/s receive front end: strips preamble/SFD, packs dibits into bytes,
// streams them out one byte behind the wire and checks the CRC-32 residue at frame end.
module rmii_rx_fcs_check #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1522,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [1:0]  rxd,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        frame_done,
  output logic        fcs_ok,
  output logic        err_runt,
  output logic        err_giant,
  output logic        err_align,
  output logic [10:0] frame_len
);

  localparam logic [31:0] POLY  = 32'hEDB88320;
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_t;

  state_t      r_state;
  logic [31:0] r_crc;
  logic [5:0]  r_part;
  logic [1:0]  r_dib;
  logic [7:0]  r_hold;
  logic        r_hold_vld;
  logic [10:0] r_bytes;

  logic [31:0] w_crc_next;
  logic [7:0]  w_byte;
  logic        w_runt;
  logic        w_giant;
  logic        w_align;

  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_comb begin
    w_crc_next = crc_dibit(r_crc, rxd);
    w_byte     = {rxd, r_part};
    w_runt     = (r_bytes < MIN_L);
    w_giant    = (r_bytes > MAX_L);
    w_align    = (r_dib != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_DROP;
      r_crc      <= '1;
      r_part     <= '0;
      r_dib      <= '0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_bytes    <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      fcs_ok     <= 1'b0;
      err_runt   <= 1'b0;
      err_giant  <= 1'b0;
      err_align  <= 1'b0;
      frame_len  <= '0;
    end else begin
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        S_DROP: begin
          if (!rx_dv) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (rx_dv) r_state <= (rxd == 2'b01) ? S_PREAMBLE : S_DROP;
        end
        S_PREAMBLE: begin
          if (!rx_dv) begin
            r_state <= S_IDLE;
          end else begin
            case (rxd)
              2'b01: r_state <= S_PREAMBLE;
              2'b11: begin
                r_state    <= S_DATA;
                r_crc      <= '1;
                r_part     <= '0;
                r_dib      <= '0;
                r_bytes    <= '0;
                r_hold_vld <= 1'b0;
              end
              default: r_state <= S_DROP;
            endcase
          end
        end
        S_DATA: begin
          if (rx_dv) begin
            r_crc <= w_crc_next;
            r_dib <= r_dib + 2'd1;
            if (r_dib == 2'd3) begin
              // Hold one byte back so the final byte can carry m_last once rx_dv drops.
              r_hold     <= w_byte;
              r_hold_vld <= 1'b1;
              if (r_hold_vld) begin
                m_data  <= r_hold;
                m_valid <= 1'b1;
              end
              if (r_bytes != 11'h7FF) r_bytes <= r_bytes + 11'd1;
            end else begin
              r_part[{r_dib, 1'b0} +: 2] <= rxd;
            end
          end else begin
            if (r_hold_vld) begin
              m_data  <= r_hold;
              m_valid <= 1'b1;
              m_last  <= 1'b1;
            end
            frame_done <= 1'b1;
            fcs_ok     <= (r_crc == RESIDUE) & ~w_runt & ~w_giant & ~w_align;
            err_runt   <= w_runt;
            err_giant  <= w_giant;
            err_align  <= w_align;
            frame_len  <= r_bytes;
            r_hold_vld <= 1'b0;
            r_part     <= '0;
            r_dib      <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_DROP;
      endcase
    end
  end

endmodule

// File: doc/rmii_rx_fcs_check.md
Name: rmii_rx_fcs_check

Overview:
- RMII receive front end for the Ethernet MAC, 100 Mb/s mode: one dibit per clock on the 50 MHz RMII reference clock.
- Strips preamble/SFD, packs LSB-first dibits into bytes and streams them out with a last flag.
- Runs the CRC-32 over every post-SFD dibit, including the FCS, and checks the residue at frame end.
- Counterpart of the TX-side FCS generator; sits between the RMII pins (after the crs_dv de-glitch stage) and the RX buffer.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes incl. FCS; shorter frames flag runt.
MAX_LEN, 1522, maximum legal frame length in bytes incl. FCS; longer frames flag giant.
RESIDUE, 32'hDEBB20E3, expected non-complemented CRC register value after the FCS has been processed.

Ports:
clk  input  1  RMII 50 MHz reference clock
rst_n  input  1  asynchronous active-low reset
rx_dv  input  1  receive data valid (de-glitched crs_dv)
rxd  input  2  receive dibit; rxd[0] is the earlier bit
m_data  output  8  received byte
m_valid  output  1  one-cycle strobe: m_data valid
m_last  output  1  qualifies m_valid: final byte of the frame (last FCS byte)
frame_done  output  1  one-cycle end-of-frame pulse
fcs_ok  output  1  valid with frame_done: residue matched and no other error
err_runt  output  1  valid with frame_done: length < MIN_LEN
err_giant  output  1  valid with frame_done: length > MAX_LEN
err_align  output  1  valid with frame_done: dibit count not a multiple of 4
frame_len  output  11  valid with frame_done: whole bytes received after SFD, saturating at 2047

Behaviour:
- Reset (async, rst_n low): all outputs 0, CRC register 32'hFFFFFFFF, state DROP.
- States: IDLE, PREAMBLE, DATA, DROP.
- DROP: wait for rx_dv==0, then go to IDLE. Prevents locking onto a frame already in progress at reset release or after an error.
- IDLE: rx_dv==1 and rxd==2'b01 -> PREAMBLE. rx_dv==1 with any other rxd -> DROP. No outputs.
- PREAMBLE:
  - rxd==01: stay.
  - rxd==11: SFD tail -> DATA; CRC register <= FFFFFFFF; byte/dibit counters cleared.
  - rxd==00 or 10: -> DROP, no frame_done.
  - rx_dv==0: -> IDLE, no frame_done.
- DATA, each clock with rx_dv==1:
  - Shift rxd into the byte assembler at bit positions [2k+1:2k], k = dibit index mod 4.
  - CRC update, data d=rxd, reflected shift-right form:
    - bits 31/30: c[31]=c[1]^d[1], c[30]=c[0]^c[1]^d[0]^d[1].
    - bits 29:0: standard 802.3 reflected 2-bit step, polynomial 0xEDB88320, two bits per clock, d[0] first.
  - On the 4th dibit: the completed byte enters a one-byte hold register. If the hold register was already occupied, its old byte is emitted: m_valid=1, m_last=0 on the next cycle. Byte count +1.
- DATA, rx_dv==0 (frame end), on the following cycle:
  - If the hold register is occupied: emit it with m_valid=1, m_last=1.
  - frame_done=1.
  - fcs_ok = (crc==RESIDUE) & ~runt & ~giant & ~align.
  - Error flags and frame_len valid; next state IDLE.
  - Hold register and partial byte are cleared.
  - Zero-byte frame: frame_done with err_runt=1, fcs_ok=0, no m_valid.
- Latency: byte N is emitted 1 cycle after the 4th dibit of byte N+1 is sampled. The last byte is emitted 1 cycle after rx_dv is sampled low.
- Partial trailing dibits (err_align): not emitted. The CRC still includes them, so the residue normally fails.
- Giant: bytes above MAX_LEN are still streamed; err_giant is reported at frame end. frame_len saturates.
- Back-to-back frames: a single cycle of rx_dv==0 is sufficient between frames. A new preamble dibit may arrive on the cycle frame_done is asserted.
- Reset mid-frame: outputs clear immediately. No frame_done or m_last is issued for the aborted frame. After release the block stays in DROP until rx_dv is low.
- No backpressure; the downstream must accept every m_valid.

Test Plan:
- Good frame: 7×0x55 + 0xD5, 60 payload bytes 0x00..0x3B, correct FCS -> 64 m_valid; m_last on the 64th; frame_done with fcs_ok=1, frame_len=64, all errors 0.
- Same frame with payload byte 10 bit 3 flipped -> identical byte stream incl. flipped byte; frame_done with fcs_ok=0, other errors 0.
- Runt: 56-byte payload + valid FCS (60 bytes) -> fcs_ok=0, err_runt=1, frame_len=60; residue internally matches.
- Alignment: good 64-byte frame + 1 extra dibit -> 64 bytes emitted, err_align=1, fcs_ok=0.
- Preamble error: dibits 01,01,10,... -> no m_valid, no frame_done; the next good frame is received correctly after rx_dv low.
- Reset and back-to-back: assert rst_n low at byte 20 of frame A -> outputs 0 immediately, no frame_done. Release with rx_dv still high -> nothing until rx_dv low. Then two good frames separated by one idle cycle -> two frame_done pulses, both fcs_ok=1.
